// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start bit, DATA_W data bits LSB first, optional even parity, stop bit.
// Good frames go out on a valid/ready buffer; bad or overrun frames raise one-cycle flags.
module serial_frame_rx #(
    parameter int DATA_W    = 8,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic              clk,
    input  logic              clear_n,
    input  logic              si,
    input  logic              ready,
    output logic [DATA_W-1:0] data_out,
    output logic              valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun
);
    localparam int CW = $clog2(DATA_W);
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DATA   = 2'd1;
    localparam logic [1:0] PARITY = 2'd2;
    localparam logic [1:0] STOP   = 2'd3;

    logic [1:0]        r_state;
    logic [CW-1:0]     r_cnt;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] r_data;
    logic              r_par;
    logic              r_valid;
    logic              r_perr;
    logic              r_ferr;
    logic              r_ovr;
    logic              w_par_bad;

    // r_par accumulates data XOR parity bit; nonzero at STOP means odd total
    assign w_par_bad = PARITY_EN && r_par;

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_par   <= 1'b0;
            r_valid <= 1'b0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_perr <= 1'b0;
            r_ferr <= 1'b0;
            r_ovr  <= 1'b0;
            if (r_valid && ready)
                r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!si) begin
                        r_state <= DATA;
                        r_cnt   <= '0;
                        r_par   <= 1'b0;
                    end
                end
                DATA: begin
                    r_shift[r_cnt] <= si;
                    r_par          <= r_par ^ si;
                    r_cnt          <= r_cnt + CW'(1);
                    if (r_cnt == LAST)
                        r_state <= PARITY_EN ? PARITY : STOP;
                end
                PARITY: begin
                    r_par   <= r_par ^ si;
                    r_state <= STOP;
                end
                STOP: begin
                    // Always back to IDLE: a zero stop bit is not taken as a new start
                    r_state <= IDLE;
                    r_ferr  <= !si;
                    r_perr  <= w_par_bad;
                    if (si && !w_par_bad) begin
                        if (!r_valid || ready) begin
                            r_data  <= r_shift;
                            r_valid <= 1'b1;
                        end else begin
                            r_ovr <= 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign data_out   = r_data;
    assign valid      = r_valid;
    assign parity_err = r_perr;
    assign frame_err  = r_ferr;
    assign overrun    = r_ovr;
endmodule
